// File: rtl/flash_read_arbiter.sv
`default_nettype none
// ============================================================================
// flash_read_arbiter : round-robin shared SPI boot-flash word reader (F/D ports)
// Option macro FLASH_READ_ARBITER_FAST_READ_EN : 0x0B fast read with dummy byte
// Revision 1.0
// ============================================================================
module flash_read_arbiter #(
  parameter int CLK_DIV  = 1,
  parameter int CSB_IDLE = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        f_req,
  input  logic [23:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic [23:0] d_addr,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_sck,
  output logic        flash_mosi,
  input  logic        flash_miso
);

`ifdef FLASH_READ_ARBITER_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
  localparam int         TX_W     = 40;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
  localparam int         TX_W     = 32;
`endif
  localparam int                NBITS     = TX_W + 32;
  localparam logic [6:0]        LAST_BIT  = 7'(NBITS - 1);
  localparam logic [23:0]       ADDR_MASK = 24'hFFFFFC;
  localparam int                DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam int                GAP_W     = (CSB_IDLE > 1) ? $clog2(CSB_IDLE) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CSB_IDLE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]       state_q,   state_d;
  logic             pref_d_q,  pref_d_d;
  logic             grant_d_q, grant_d_d;
  logic [TX_W-1:0]  tx_q,      tx_d;
  logic [31:0]      rx_q,      rx_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic [6:0]       bit_q,     bit_d;
  logic             phase_q,   phase_d;
  logic [GAP_W-1:0] gap_q,     gap_d;
  logic             csb_q,     csb_d;
  logic             sck_q,     sck_d;
  logic             busy_q,    busy_d;
  logic             f_ack_q,   f_ack_d;
  logic             d_ack_q,   d_ack_d;
  logic [31:0]      f_rdata_q, f_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;

  logic             take_d;
  logic [23:0]      sel_addr;
  logic [TX_W-1:0]  tx_load;
  logic [31:0]      word;

  always_comb begin
    state_d   = state_q;
    pref_d_d  = pref_d_q;
    grant_d_d = grant_d_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    div_d     = div_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    gap_d     = gap_q;
    csb_d     = csb_q;
    sck_d     = sck_q;
    busy_d    = busy_q;
    f_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;

    // D wins only when F is absent or when F was served last.
    take_d   = d_req && (!f_req || pref_d_q);
    sel_addr = take_d ? d_addr : f_addr;
`ifdef FLASH_READ_ARBITER_FAST_READ_EN
    tx_load  = {CMD_BYTE, sel_addr & ADDR_MASK, 8'h00};
`else
    tx_load  = {CMD_BYTE, sel_addr & ADDR_MASK};
`endif
    // First received byte sits in rx_q[31:24] and belongs in the low byte.
    word     = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};

    case (state_q)
      S_IDLE: begin
        if (f_req || d_req) begin
          grant_d_d = take_d;
          pref_d_d  = !take_d;
          tx_d      = tx_load;
          csb_d     = 1'b0;
          sck_d     = 1'b0;
          busy_d    = 1'b1;
          div_d     = '0;
          bit_d     = '0;
          phase_d   = 1'b0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sck_d   = 1'b1;
            rx_d    = {rx_q[30:0], flash_miso};
          end else begin
            phase_d = 1'b0;
            sck_d   = 1'b0;
            tx_d    = {tx_q[TX_W-2:0], 1'b0};
            if (bit_q == LAST_BIT) begin
              csb_d   = 1'b1;
              state_d = S_ACK;
              if (grant_d_q) begin
                d_ack_d   = 1'b1;
                d_rdata_d = word;
              end else begin
                f_ack_d   = 1'b1;
                f_rdata_d = word;
              end
            end else begin
              bit_d = bit_q + 7'd1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_ACK: begin
        // The ACK cycle is the first of the CSB_IDLE high cycles.
        if (CSB_IDLE > 1) begin
          gap_d   = GAP_W'(1);
          state_d = S_GAP;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        if (gap_q == GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      pref_d_q  <= 1'b0;
      grant_d_q <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      gap_q     <= '0;
      csb_q     <= 1'b1;
      sck_q     <= 1'b0;
      busy_q    <= 1'b0;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      pref_d_q  <= pref_d_d;
      grant_d_q <= grant_d_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      gap_q     <= gap_d;
      csb_q     <= csb_d;
      sck_q     <= sck_d;
      busy_q    <= busy_d;
      f_ack_q   <= f_ack_d;
      d_ack_q   <= d_ack_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign f_ack      = f_ack_q;
  assign d_ack      = d_ack_q;
  assign f_rdata    = f_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign busy       = busy_q;
  assign flash_csb  = csb_q;
  assign flash_sck  = sck_q;
  assign flash_mosi = tx_q[TX_W-1];

endmodule
`default_nettype wire

// File: tb/tb_flash_read_arbiter.sv
`default_nettype none
// Bench for flash_read_arbiter: behavioural SPI flash models on a CLK_DIV=1 and a
// CLK_DIV=3 instance, random requests checked against an arbitration/data model.
module tb_flash_read_arbiter;

`ifdef FLASH_READ_ARBITER_FAST_READ_EN
  localparam int         NB  = 72;
  localparam logic [7:0] CMD = 8'h0B;
`else
  localparam int         NB  = 64;
  localparam logic [7:0] CMD = 8'h03;
`endif
  localparam int HDR      = NB - 32;
  localparam int IDLE_GAP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        f_req = 1'b0, d_req = 1'b0;
  logic [23:0] f_addr = '0, d_addr = '0;
  logic        f_ack, d_ack, busy, csb, sck, mosi;
  logic        miso = 1'b0;
  logic [31:0] f_rdata, d_rdata;

  logic        f3_req = 1'b0, d3_req = 1'b0;
  logic [23:0] f3_addr = '0, d3_addr = '0;
  logic        f3_ack, d3_ack, busy3, csb3, sck3, mosi3;
  logic        miso3 = 1'b0;
  logic [31:0] f3_rdata, d3_rdata;

  flash_read_arbiter #(.CLK_DIV(1), .CSB_IDLE(IDLE_GAP)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_rdata(d_rdata),
    .busy(busy), .flash_csb(csb), .flash_sck(sck), .flash_mosi(mosi), .flash_miso(miso)
  );

  flash_read_arbiter #(.CLK_DIV(3), .CSB_IDLE(IDLE_GAP)) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .f_req(f3_req), .f_addr(f3_addr), .f_ack(f3_ack), .f_rdata(f3_rdata),
    .d_req(d3_req), .d_addr(d3_addr), .d_ack(d3_ack), .d_rdata(d3_rdata),
    .busy(busy3), .flash_csb(csb3), .flash_sck(sck3), .flash_mosi(mosi3), .flash_miso(miso3)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic model_last_d = 1'b1;  // "F preferred" after reset

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        csb_p;
    logic        sck_p;
    logic        mosi_p;
    logic        miso;
    int          nbits;
    logic [71:0] bits;
    logic [23:0] addr;
    int          glitch;
    int          run;
    int          run_bad;
    int          csb_fall;
  } fst_t;

  fst_t fs1, fs3;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000104: return 8'h11;
      24'h000105: return 8'h22;
      24'h000106: return 8'h33;
      24'h000107: return 8'h44;
      default:    return (a[7:0] * 8'd29) ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [23:0] b;
    b = a & 24'hFFFFFC;
    return {mem_byte(b + 24'd3), mem_byte(b + 24'd2), mem_byte(b + 24'd1), mem_byte(b)};
  endfunction

  function automatic logic [71:0] exp_bits(input logic [23:0] a);
    logic [71:0] e;
    e = {CMD, a & 24'hFFFFFC, 40'h0};
    return e >> (72 - NB);
  endfunction

  // SPI flash: captures MOSI on sck rise, drives MISO after sck fall.
  function automatic fst_t flash_step(input fst_t s_in, input logic c, input logic k,
                                      input logic m, input int now, input int div);
    fst_t s;
    int j;
    logic [7:0] byt;
    s = s_in;
    if (s.csb_p && !c) begin
      s.nbits = 0; s.bits = '0; s.csb_fall = now; s.run = 1;
    end else if (!c) begin
      if (k && !s.sck_p) begin
        s.bits  = {s.bits[70:0], m};
        s.nbits = s.nbits + 1;
        if (s.nbits == 32) s.addr = s.bits[23:0];
      end
      if (!k && s.sck_p && s.nbits >= HDR && s.nbits < NB) begin
        j = s.nbits - HDR;
        byt = mem_byte(s.addr + 24'(j / 8));
        s.miso = byt[7 - (j % 8)];
      end
      if (k && s.sck_p && m !== s.mosi_p) s.glitch = s.glitch + 1;
      if (k != s.sck_p) begin
        if (s.run != div) s.run_bad = s.run_bad + 1;
        s.run = 1;
      end else begin
        s.run = s.run + 1;
      end
    end else if (!s.csb_p) begin
      if (s.run != div) s.run_bad = s.run_bad + 1;
    end
    s.csb_p = c; s.sck_p = k; s.mosi_p = m;
    return s;
  endfunction

  initial begin
    fs1 = '0; fs1.csb_p = 1'b1;
    fs3 = '0; fs3.csb_p = 1'b1;
  end

  always @(negedge clk) begin
    fs1  = flash_step(fs1, csb, sck, mosi, cyc, 1);
    miso = fs1.miso;
    fs3  = flash_step(fs3, csb3, sck3, mosi3, cyc, 3);
    miso3 = fs3.miso;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input int budget, output int ack_at, output logic got);
    got = 1'b0;
    ack_at = -1;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (f_ack || d_ack) begin
        got = 1'b1;
        ack_at = cyc;
      end
    end
  endtask

  // One transaction on the CLK_DIV=1 instance with all per-read checks inline.
  task automatic do_read(input logic rf, input logic rd, input logic [23:0] af,
                         input logic [23:0] ad, input logic exp_d, input int exp_ack_in,
                         input logic drop_all, input string tag, output int ack_at);
    int          exp_ack;
    logic        got;
    logic [31:0] other_before;
    logic [31:0] got_data;
    logic [23:0] a;
    step();
    if (rf) begin f_req = 1'b1; f_addr = af; end
    if (rd) begin d_req = 1'b1; d_addr = ad; end
    exp_ack      = (exp_ack_in >= 0) ? exp_ack_in : cyc + 1 + 2 * NB;
    a            = exp_d ? d_addr : f_addr;
    other_before = exp_d ? f_rdata : d_rdata;
    wait_ack(4000, ack_at, got);
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_timeout: no ack seen, wanted ack at cycle %0d", tag, exp_ack);
      f_req = 1'b0; d_req = 1'b0;
      return;
    end
    total++;
    if ({f_ack, d_ack} !== (exp_d ? 2'b01 : 2'b10)) begin
      bad++;
      $display("FAIL %s_winner: f_ack,d_ack=%b want %b", tag, {f_ack, d_ack}, exp_d ? 2'b01 : 2'b10);
    end
    total++;
    if (ack_at !== exp_ack) begin
      bad++;
      $display("FAIL %s_ack_time: ack at %0d want %0d", tag, ack_at, exp_ack);
    end
    total++;
    if (ack_at - fs1.csb_fall !== 2 * NB) begin
      bad++;
      $display("FAIL %s_csb_to_ack: %0d cycles want %0d", tag, ack_at - fs1.csb_fall, 2 * NB);
    end
    got_data = exp_d ? d_rdata : f_rdata;
    total++;
    if (got_data !== exp_word(a)) begin
      bad++;
      $display("FAIL %s_rdata: got %h want %h (addr %h)", tag, got_data, exp_word(a), a);
    end
    total++;
    if (fs1.nbits !== NB || fs1.bits !== exp_bits(a)) begin
      bad++;
      $display("FAIL %s_mosi: bits=%h n=%0d want %h n=%0d", tag, fs1.bits, fs1.nbits, exp_bits(a), NB);
    end
    total++;
    if ((exp_d ? f_rdata : d_rdata) !== other_before) begin
      bad++;
      $display("FAIL %s_other_rdata: got %h want %h", tag, exp_d ? f_rdata : d_rdata, other_before);
    end
    total++;
    if (fs1.glitch !== 0) begin
      bad++;
      $display("FAIL %s_mosi_while_sck_high: changes=%0d want 0", tag, fs1.glitch);
    end
    if (exp_d) d_req = 1'b0; else f_req = 1'b0;
    if (drop_all) begin f_req = 1'b0; d_req = 1'b0; end
    step();
    total++;
    if ({f_ack, d_ack, busy, csb} !== 4'b0011) begin
      bad++;
      $display("FAIL %s_after_ack: f_ack,d_ack,busy,csb=%b want 0011", tag, {f_ack, d_ack, busy, csb});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++;
    if ({csb, sck, mosi, f_ack, d_ack, busy} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_pins: got %b want 100000", {csb, sck, mosi, f_ack, d_ack, busy});
    end
    total++;
    if (f_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_rdata: f=%h d=%h want 0", f_rdata, d_rdata);
    end
    total++;
    if ({csb3, sck3, mosi3, f3_ack, d3_ack, busy3} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_pins_div3: got %b want 100000", {csb3, sck3, mosi3, f3_ack, d3_ack, busy3});
    end
    rst = 1'b0;
    model_last_d = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    int a1;
    do_read(1'b1, 1'b0, 24'h000104, 24'h0, 1'b0, -1, 1'b1, "single", a1);
    model_last_d = 1'b0;
    total++;
    if (f_rdata !== 32'h44332211) begin
      bad++;
      $display("FAIL single_word: got %h want 44332211", f_rdata);
    end
  endtask

  task automatic test_arbitration();
    int a1, a2;
    logic [23:0] af, ad;
    rst = 1'b1; step(); rst = 1'b0;
    af = 24'($urandom); ad = 24'($urandom);
    do_read(1'b1, 1'b1, af, ad, 1'b0, -1, 1'b0, "arb_first", a1);
    do_read(1'b0, 1'b1, af, ad, 1'b1, a1 + 1 + 2 * NB + IDLE_GAP, 1'b1, "arb_second", a2);
    model_last_d = 1'b1;
    total++;
    if (fs1.csb_fall - a1 < IDLE_GAP) begin
      bad++;
      $display("FAIL arb_csb_gap: csb high %0d cycles want >= %0d", fs1.csb_fall - a1, IDLE_GAP);
    end
  endtask

  task automatic test_d_repeat();
    int a1;
    for (int i = 0; i < 3; i++) begin
      do_read(1'b0, 1'b1, 24'h0, 24'($urandom), 1'b1, -1, 1'b1, "d_repeat", a1);
    end
    do_read(1'b1, 1'b1, 24'($urandom), 24'($urandom), 1'b0, -1, 1'b1, "d_repeat_both", a1);
    model_last_d = 1'b0;
  endtask

  task automatic test_random();
    int a1;
    int choice;
    logic win_d;
    for (int i = 0; i < 8; i++) begin
      choice = $urandom_range(1, 3);
      if (choice == 3) win_d = !model_last_d;
      else             win_d = (choice == 2);
      do_read(choice != 2, choice != 1, 24'($urandom), 24'($urandom), win_d, -1, 1'b1, "random", a1);
      model_last_d = win_d;
    end
  endtask

  task automatic test_reset_mid();
    int   a1;
    int   acks;
    int   n;
    step();
    f_req = 1'b1; f_addr = 24'($urandom);
    n = 0;
    while (csb && n < 20) begin step(); n++; end
    while (fs1.nbits < 40 && n < 400) begin step(); n++; end
    total++;
    if (fs1.nbits !== 40) begin
      bad++;
      $display("FAIL midrst_reach_bit40: nbits=%0d want 40", fs1.nbits);
    end
    rst = 1'b1; f_req = 1'b0;
    step();
    rst = 1'b0;
    total++;
    if ({csb, sck, f_ack, d_ack, busy} !== 5'b10000) begin
      bad++;
      $display("FAIL midrst_pins: csb,sck,f_ack,d_ack,busy=%b want 10000", {csb, sck, f_ack, d_ack, busy});
    end
    acks = 0;
    for (int i = 0; i < 2 * NB + 20; i++) begin
      step();
      if (f_ack || d_ack || !csb) acks++;
    end
    total++;
    if (acks !== 0) begin
      bad++;
      $display("FAIL midrst_quiet: %0d ack/csb-low cycles after reset want 0", acks);
    end
    do_read(1'b1, 1'b0, 24'($urandom), 24'h0, 1'b0, -1, 1'b1, "midrst_after", a1);
    model_last_d = 1'b0;
  endtask

  task automatic test_clkdiv3();
    int   t, ack3;
    logic got;
    logic [23:0] a;
    for (int r = 0; r < 2; r++) begin
      a = (r == 0) ? 24'hFFFFFC : 24'($urandom);
      step();
      f3_req = 1'b1; f3_addr = a; t = cyc;
      got = 1'b0; ack3 = -1;
      for (int i = 0; i < 2000 && !got; i++) begin
        step();
        if (f3_ack || d3_ack) begin got = 1'b1; ack3 = cyc; end
      end
      total++;
      if (!got || ack3 !== t + 1 + 2 * NB * 3) begin
        bad++;
        $display("FAIL div3_ack_time: ack at %0d want %0d", ack3, t + 1 + 2 * NB * 3);
      end
      total++;
      if ({f3_ack, d3_ack} !== 2'b10 || f3_rdata !== exp_word(a)) begin
        bad++;
        $display("FAIL div3_rdata: acks=%b data=%h want 10 %h", {f3_ack, d3_ack}, f3_rdata, exp_word(a));
      end
      total++;
      if (fs3.csb_fall !== t + 1 || fs3.run_bad !== 0) begin
        bad++;
        $display("FAIL div3_sck_shape: csb_fall=%0d want %0d, bad runs=%0d want 0", fs3.csb_fall, t + 1, fs3.run_bad);
      end
      total++;
      if (fs3.bits !== exp_bits(a)) begin
        bad++;
        $display("FAIL div3_mosi: got %h want %h", fs3.bits, exp_bits(a));
      end
      f3_req = 1'b0;
      step();
      total++;
      if (f3_ack !== 1'b0) begin
        bad++;
        $display("FAIL div3_ack_pulse: f3_ack=%b want 0", f3_ack);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_arbitration();
    test_d_repeat();
    test_random();
    test_reset_mid();
    test_clkdiv3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Read-only SPI flash controller for the user-area boot flash on the mprj_io pins (csb, sck, io0 = MOSI, io1 = MISO).
- Shares that single flash between two Microwatt requesters: instruction fetch (port F) and data load (port D).
- Each request is one 32-bit word read. The block arbitrates between ports, runs the SPI read sequence, assembles a little-endian word and returns it with a one-cycle ack.

Parameters:
- CLK_DIV, 1, SPI half-period in wb_clk_i cycles (>=1); sck period = 2*CLK_DIV cycles.
- CSB_IDLE, 2, minimum cycles csb held high between transactions (>=1).

Ports:
- wb_clk_i  input  1  sole clock; all logic on rising edge.
- wb_rst_i  input  1  reset, synchronous, active-high.
- f_req  input  1  port F request; held high until f_ack.
- f_addr  input  24  port F byte address; bits[1:0] ignored and sent as 00.
- f_ack  output  1  one-cycle pulse; f_rdata valid this cycle only.
- f_rdata  output  32  port F read data.
- d_req / d_addr / d_ack / d_rdata  same as port F, for port D.
- busy  output  1  high from grant until csb idle time has expired.
- flash_csb  output  1  chip select, active-low.
- flash_sck  output  1  SPI clock, mode 0 (idles low).
- flash_mosi  output  1  to flash io0.
- flash_miso  input  1  from flash io1.

Behaviour:
- Reset: flash_csb=1, flash_sck=0, flash_mosi=0, f_ack=d_ack=0, rdata=0, busy=0. State=IDLE; round-robin pointer = "F preferred".
- States: IDLE -> SHIFT -> ACK -> GAP -> IDLE.
- IDLE: samples f_req/d_req at cycle T.
  - Only one request high: that port is granted.
  - Both high: grant the port not granted last time. After reset, F wins.
  - Grant latches the address and port id. Pointer updates at grant.
- SHIFT:
  - csb goes low at T+1 and stays low through the last bit.
  - Bit n (n=0..63) occupies cycles [T+1+2n*CLK_DIV, T+1+(2n+2)*CLK_DIV): CLK_DIV cycles sck low, then CLK_DIV cycles sck high.
  - MOSI changes only while sck is low. MISO is sampled on the clock edge that drives sck high.
  - Bit stream, MSB-first: command 0x03 (8 bits), then addr[23:2],2'b00 (24 bits), then 32 data bits.
  - MOSI=0 during data bits.
- Data assembly: received byte k (k=0..3, in arrival order) goes to rdata[8k+7:8k]; within each byte, first bit = bit 7.
- ACK, at cycle T+1+128*CLK_DIV: sck=0, csb=1, granted port ack=1 for exactly one cycle, that port's rdata updated. The other port's ack stays 0.
  - rdata holds its value until that port's next ack.
- GAP: csb stays high for CSB_IDLE cycles counted from the ACK cycle. No grant until GAP completes; busy drops when IDLE is re-entered.
- Earliest next grant is T+1+128*CLK_DIV+CSB_IDLE. CLK_DIV=1, CSB_IDLE=2: ack at T+129, next grant sampled at T+131.
- Boundary cases:
  - Requester drops req mid-transaction (protocol violation): transfer still completes and ack still pulses.
  - req is ignored outside IDLE.
  - Address wraps naturally in the flash; no range check.
  - wb_rst_i mid-transaction: next cycle csb=1, sck=0, acks 0, state IDLE, pointer reset, partial data discarded.
  - Back-to-back requests from the same port while the other is idle are served consecutively.

Optional Feature:
- Macro FLASH_READ_ARBITER_FAST_READ_EN.
- Defined:
  - Command 0x0B.
  - 8 dummy bits (MOSI=0, MISO ignored) inserted between address and data; 72 bits total.
  - ack at T+1+144*CLK_DIV.
- Undefined: command 0x03, 64 bits, timing as above. No dummy-counter logic is synthesised.

Test Plan:
1. Reset, then f_req with f_addr=0x000104, flash model word 0x44332211 at 0x104 (bytes 11,22,33,44), CLK_DIV=1 -> MOSI shows 0x03,0x000104; f_ack at T+129; f_rdata=0x44332211; d_ack stays 0.
2. f_req and d_req asserted together twice back-to-back -> first grant F, second grant D. csb high for >=2 cycles between transactions; second ack at first ack + 131.
3. d_req alone three times -> D served each time. Pointer does not starve D; F untouched.
4. CLK_DIV=3 -> sck high/low 3 cycles each; ack at T+1+384. Data correct at addr 0xFFFFFC.
5. wb_rst_i pulsed at bit 40 of a transfer -> next cycle csb=1, sck=0, no ack. Subsequent f_req completes correctly.
6. With FLASH_READ_ARBITER_FAST_READ_EN -> command 0x0B, 8 dummy sck pulses; ack at T+145 (CLK_DIV=1); same data as scenario 1.
